// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared constants, FSM state encoding and queue entry layout for the fetch sequencer.
package imem_fetch_ctrl_pkg;

  localparam int          XLEN       = 32;
  localparam int          ILEN_BYTES = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // 65-bit queue entry: {pc, instr, fault}
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Two-entry synchronous FIFO of fetch entries; head is registered, flush empties it in one edge.
// Caller only pushes when there is space (count<2 or popping) and only pops when count>0.
module fetch_queue
  import imem_fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t push_dat_i,
  output fetch_entry_t head_dat_o,
  output logic         head_vld_o,
  output logic [1:0]   count_o
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) entry0_d = push_dat_i;
          else                 entry1_d = push_dat_i;
          count_d = 2'(count_q + 2'd1);
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = 2'(count_q - 2'd1);
        end
        2'b11: begin
          // Simultaneous pop and push: occupancy stays, the new entry lands behind the survivor.
          if (count_q == 2'd1) begin
            entry0_d = push_dat_i;
          end else begin
            entry0_d = entry1_q;
            entry1_d = push_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head_dat_o = entry0_q;
  assign head_vld_o = (count_q != 2'd0);
  assign count_o    = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, fetches one word per cycle into a 2-entry queue toward decode.
// Illegal addresses produce a single fault entry and park the FSM in HALT until redirect or reset.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_SIZE - ILEN_BYTES);

  logic [31:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;

  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic [1:0]   q_count;
  logic         head_vld;
  logic         fetch_legal;
  logic         pop;
  logic         space;
  logic         push;

  // Full 32-bit compare so addresses near 2^32 can never alias back into the memory.
  assign fetch_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_WORD);

  assign pop   = head_vld && out_ready;
  assign space = (q_count < 2'd2) || pop;
  assign push  = !redirect_valid && (state_q == ST_RUN) && space;

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = fetch_legal ? imem_rdata : NOP_INSTR;
  assign push_entry.fault = !fetch_legal;

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else if (push) begin
      if (fetch_legal) pc_d    = pc_q + 32'(ILEN_BYTES);
      else             state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_queue u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .pop_i      (pop),
    .push_dat_i (push_entry),
    .head_dat_o (head_entry),
    .head_vld_o (head_vld),
    .count_o    (q_count)
  );

  assign imem_addr = pc_q;
  assign out_valid = head_vld;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;
  assign out_fault = head_entry.fault;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a combinational instruction memory model.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  logic [31:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  imem_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_SIZE (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 32'd1024) imem_rdata = mem[imem_addr[9:2]];
    else                      imem_rdata = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic fault);
    check({tag, "_vld"},   {31'd0, out_valid}, 32'd1);
    check({tag, "_pc"},    out_pc, pc);
    check({tag, "_instr"}, out_instr, instr);
    check({tag, "_fault"}, {31'd0, out_fault}, {31'd0, fault});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hA5A5, 16'(i)};
    mem[0]  = 32'h0000_0000;
    mem[1]  = 32'h0040_0093;
    mem[2]  = 32'h0010_0113;
    mem[14] = 32'hFFD0_0713;
    mem[15] = 32'h4047_5793;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    step(); step();
    check("rst_vld",   {31'd0, out_valid}, 32'd0);
    check("rst_pc",    out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_fault", {31'd0, out_fault}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);

    // Streaming from reset with decode always ready.
    rst = 1'b0;
    step(); check_head("boot0", 32'h00, 32'h0000_0000, 1'b0);
    check("boot0_addr", imem_addr, 32'h04);
    step(); check_head("boot1", 32'h04, 32'h0040_0093, 1'b0);
    step(); check_head("boot2", 32'h08, 32'h0010_0113, 1'b0);

    // Backpressure: queue fills and PC holds.
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_head("full", 32'h00, 32'h0000_0000, 1'b0);
    check("full_addr", imem_addr, 32'h08);
    out_ready = 1'b1;
    step(); check_head("drain1", 32'h04, 32'h0040_0093, 1'b0);
    step(); check_head("drain2", 32'h08, 32'h0010_0113, 1'b0);

    // Redirect while full.
    out_ready = 1'b0;
    step();
    check("hold_addr", imem_addr, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h38;
    step();
    redirect_valid = 1'b0;
    check("flush_vld", {31'd0, out_valid}, 32'd0);
    check("flush_addr", imem_addr, 32'h38);
    step(); check_head("tgt0", 32'h38, 32'hFFD0_0713, 1'b0);
    step(); check_head("tgt0_hold", 32'h38, 32'hFFD0_0713, 1'b0);
    out_ready = 1'b1;
    step(); check_head("tgt1", 32'h3C, 32'h4047_5793, 1'b0);

    // Misaligned redirect produces one fault entry, then HALT.
    redirect_valid = 1'b1; redirect_pc = 32'h3A;
    step();
    redirect_valid = 1'b0;
    step(); check_head("mis", 32'h3A, 32'h0000_0013, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_vld", {31'd0, out_valid}, 32'd0);
    end
    check("halt_addr", imem_addr, 32'h3A);
    redirect_valid = 1'b1; redirect_pc = 32'h04;
    step();
    redirect_valid = 1'b0;
    step(); check_head("resume", 32'h04, 32'h0040_0093, 1'b0);

    // Upper boundary of memory and top of address space.
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    step();
    redirect_valid = 1'b0;
    step(); check_head("last", 32'h3FC, 32'hA5A5_00FF, 1'b0);
    step(); check_head("past", 32'h400, 32'h0000_0013, 1'b1);
    step();
    check("past_vld", {31'd0, out_valid}, 32'd0);
    check("past_addr", imem_addr, 32'h400);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step(); check_head("top", 32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
    step();
    check("top_vld", {31'd0, out_valid}, 32'd0);
    check("top_nowrap", imem_addr, 32'hFFFF_FFFC);

    // Reset beats a simultaneous redirect while the queue is full.
    redirect_valid = 1'b1; redirect_pc = 32'h10; out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    step(); step();
    check_head("pre_rst", 32'h10, 32'hA5A5_0004, 1'b0);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h38;
    step();
    rst = 1'b0; redirect_valid = 1'b0;
    check("rst2_vld", {31'd0, out_valid}, 32'd0);
    check("rst2_addr", imem_addr, 32'h0);
    out_ready = 1'b1;
    step(); check_head("rst2_boot", 32'h00, 32'h0000_0000, 1'b0);
    check("rst2_next", imem_addr, 32'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer that drives the combinational, byte-addressed, little-endian instruction memory and feeds the decode stage. It owns the program counter and performs one word fetch per cycle. Fetched {pc, instruction} pairs are buffered in a 2-entry queue with a valid/ready handshake toward decode. It also accepts branch/jump redirects and flags illegal fetch addresses instead of reading out of range.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `IMEM_SIZE`, 1024: instruction memory size in bytes. Must match the memory instance.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `imem_addr`  out  32: byte address presented to the memory's `PC` input.
- `imem_rdata`  in  32: memory's `instruction` output. Combinational, same cycle as `imem_addr`.
- `redirect_valid`  in  1: one-cycle request to restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: redirect target byte address.
- `out_valid`  out  1: queue head holds a fetched entry.
- `out_ready`  in  1: decode accepts the head this cycle.
- `out_pc`  out  32: PC of the head entry.
- `out_instr`  out  32: instruction of the head entry.
- `out_fault`  out  1: head entry is a fetch fault, not an instruction.

## Operation
- State: `pc` (32), queue of 2 entries {pc, instr, fault}, `count` (0–2), FSM {RUN, HALT}.
- `imem_addr = pc` at all times. Memory is combinational, so the word fetched in a cycle is `imem_rdata` sampled at that edge.
- Legal fetch: `pc[1:0]==0` and `pc <= IMEM_SIZE-4`. Compare at 32-bit width. No wrap-around is ever allowed.
- Pop: `out_valid && out_ready`.
- Space is available when `count < 2` or a pop occurs in the same cycle.
- Priority on each edge, highest first:
  - `rst`: `pc<=RESET_PC`, `count<=0`, FSM<=RUN.
  - `redirect_valid`: flush the queue (`count<=0`, any pop this cycle is discarded), `pc<=redirect_pc`, FSM<=RUN. No push this cycle.
  - RUN with space and legal `pc`: push {pc, imem_rdata, 0}, then `pc<=pc+4`.
  - RUN with space and illegal `pc`: push {pc, 32'h0000_0013, 1}, FSM<=HALT, `pc` holds.
  - RUN with no space, or HALT: no push, `pc` holds.
- Pop and push in the same cycle are both honoured. `count` is unchanged.
- HALT is left only by redirect or reset. The fault entry drains normally.

## Timing
- Reset values: `out_valid=0`, `out_pc=0`, `out_instr=0`, `out_fault=0`, `imem_addr=RESET_PC`.
- `out_*` are driven from queue registers. No combinational path from `imem_rdata`, `out_ready` or `redirect_*` to `out_valid`, `out_pc`, `out_instr` or `out_fault`.
- Fetch latency: first edge with `rst=0` pushes `RESET_PC`. `out_valid` goes high right after that edge.
- Redirect latency: redirect at edge N flushes. Edge N+1 pushes the target. `out_valid` goes high after N+1. This is 2 cycles from redirect to a valid target instruction.
- Throughput: 1 instruction per cycle while `out_ready=1`.
- Full queue with `out_ready=0`: `pc` and `imem_addr` hold, and the head is stable.
- Redirect while full, while empty, or in HALT: behaves identically, always flush plus retarget.
- Reset asserted mid-stream: the queue is discarded at that edge. Partial state is never visible.

## Structure
- Shared package holds: `NOP_INSTR = 32'h0000_0013`, `XLEN = 32`, `ILEN_BYTES = 4`, and the FSM state enum.
- One sub-module, `fetch_queue`: a 2-entry synchronous FIFO with push, pop, flush and count. Entry width 65 bits.
- Top level holds the PC, the legality check and the FSM.

## Test plan
- Reset, memory preloaded with the boot test program, `out_ready=1`: entries (0x00,0x00000000), (0x04,0x00400093), (0x08,0x00100113) accepted on consecutive cycles, first `out_valid` one edge after reset release.
- `out_ready=0` for 5 cycles after reset: `count=2`, head stays (0x00,0x00000000), `imem_addr` holds 0x08. Releasing `out_ready` then delivers 0x00, 0x04, 0x08 back-to-back with no gap.
- Full queue plus redirect to 0x38: old entries never popped, next head is (0x38,0xFFD00713) two edges later, followed by (0x3C,0x40475793).
- Redirect to 0x3A: one entry with `out_fault=1`, `out_pc=0x3A`, `out_instr=0x00000013`. No further pushes for 10 cycles. A redirect to 0x04 resumes with 0x00400093.
- `IMEM_SIZE=1024`, redirect to 0x3FC, then fetch proceeds: 0x3FC is delivered normally, 0x400 is delivered as a fault, then HALT. Redirect to 0xFFFF_FFFC also faults, with no wrap to 0.
- `rst` asserted one cycle while the queue holds 2 entries and redirect is also high: after release `count=0` and fetch restarts at `RESET_PC`. The redirect is ignored.
